dpram_write_arbiter: RTL and testbench

Single-clock request arbiter that sits directly upstream of the dual-port RAM and drives both of its ports. It accepts two independent valid/ready request streams, A and B, and detects same-cycle write-write collisions to the same address. It resolves each collision deterministically with alternating priority, so the RAM never receives a colliding write pair. It also forwards write data to a concurrent cross-port read of the same address and returns read responses with fixed latency.

---
 rtl/dpram_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_dpram_write_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_write_arbiter.sv
// dpram_write_arbiter
// Arbitrates two valid/ready request streams onto the two ports of a
// dual-port RAM. Same-address write-write collisions are resolved with
// alternating priority. Read responses return two cycles after accept. A
// read that is accepted together with a write to the same address on the
// other port gets that write's data forwarded.
module dpram_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid_a,
    output logic                  req_ready_a,
    input  logic                  req_we_a,
    input  logic [ADDR_WIDTH-1:0] req_addr_a,
    input  logic [DATA_WIDTH-1:0] req_din_a,

    input  logic                  req_valid_b,
    output logic                  req_ready_b,
    input  logic                  req_we_b,
    input  logic [ADDR_WIDTH-1:0] req_addr_b,
    input  logic [DATA_WIDTH-1:0] req_din_b,

    output logic                  rsp_valid_a,
    output logic [DATA_WIDTH-1:0] rsp_data_a,
    output logic                  rsp_valid_b,
    output logic [DATA_WIDTH-1:0] rsp_data_b,

    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,

    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b,

    output logic                  conflict_pulse,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                  conflict;
    logic                  prio;
    logic                  acc_a;
    logic                  acc_b;
    logic                  same_addr;
    logic                  fwd_hit_a;
    logic                  fwd_hit_b;

    logic                  s1_valid_a;
    logic                  s1_fwd_a;
    logic [DATA_WIDTH-1:0] s1_fdata_a;
    logic                  s2_fwd_a;
    logic [DATA_WIDTH-1:0] s2_fdata_a;

    logic                  s1_valid_b;
    logic                  s1_fwd_b;
    logic [DATA_WIDTH-1:0] s1_fdata_b;
    logic                  s2_fwd_b;
    logic [DATA_WIDTH-1:0] s2_fdata_b;

    assign same_addr = (req_addr_a == req_addr_b);
    assign conflict  = req_valid_a & req_valid_b & req_we_a & req_we_b & same_addr;

    // prio=0 lets A win a collision, prio=1 lets B win
    assign req_ready_a = !(conflict & prio);
    assign req_ready_b = !(conflict & !prio);

    assign acc_a = req_valid_a & req_ready_a;
    assign acc_b = req_valid_b & req_ready_b;

    // Cross-port read of an address being written in the same cycle: the
    // RAM is read-first, so it would return the old word
    assign fwd_hit_a = acc_a & !req_we_a & acc_b & req_we_b & same_addr;
    assign fwd_hit_b = acc_b & !req_we_b & acc_a & req_we_a & same_addr;

    // Collision bookkeeping: priority toggle, saturating count, pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio           <= 1'b0;
            conflict_cnt   <= '0;
            conflict_pulse <= 1'b0;
        end else begin
            conflict_pulse <= conflict;
            if (conflict) begin
                prio <= !prio;
                if (conflict_cnt != '1)
                    conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // RAM command stage; address and data hold between accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_din_a  <= '0;
            ram_we_b   <= 1'b0;
            ram_addr_b <= '0;
            ram_din_b  <= '0;
        end else begin
            ram_we_a <= acc_a & req_we_a;
            ram_we_b <= acc_b & req_we_b;
            if (acc_a) begin
                ram_addr_a <= req_addr_a;
                ram_din_a  <= req_din_a;
            end
            if (acc_b) begin
                ram_addr_b <= req_addr_b;
                ram_din_b  <= req_din_b;
            end
        end
    end

    // Read response pipeline; stage 2 lines up with the RAM's registered dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_a  <= 1'b0;
            s1_fwd_a    <= 1'b0;
            s1_fdata_a  <= '0;
            rsp_valid_a <= 1'b0;
            s2_fwd_a    <= 1'b0;
            s2_fdata_a  <= '0;
            s1_valid_b  <= 1'b0;
            s1_fwd_b    <= 1'b0;
            s1_fdata_b  <= '0;
            rsp_valid_b <= 1'b0;
            s2_fwd_b    <= 1'b0;
            s2_fdata_b  <= '0;
        end else begin
            s1_valid_a <= acc_a & !req_we_a;
            s1_fwd_a   <= fwd_hit_a;
            if (fwd_hit_a)
                s1_fdata_a <= req_din_b;
            rsp_valid_a <= s1_valid_a;
            s2_fwd_a    <= s1_fwd_a;
            s2_fdata_a  <= s1_fdata_a;

            s1_valid_b <= acc_b & !req_we_b;
            s1_fwd_b   <= fwd_hit_b;
            if (fwd_hit_b)
                s1_fdata_b <= req_din_a;
            rsp_valid_b <= s1_valid_b;
            s2_fwd_b    <= s1_fwd_b;
            s2_fdata_b  <= s1_fdata_b;
        end
    end

    // Response data is zero outside a valid strobe, so it also reads 0 in reset
    assign rsp_data_a = rsp_valid_a ? (s2_fwd_a ? s2_fdata_a : ram_dout_a) : '0;
    assign rsp_data_b = rsp_valid_b ? (s2_fwd_b ? s2_fdata_b : ram_dout_b) : '0;

endmodule

// File: tb/tb_dpram_write_arbiter.sv
// Bench for dpram_write_arbiter: a read-first dual-port RAM model sits on the
// RAM ports, and a reference model tracks architectural memory contents, the
// next collision winner and expected responses by due cycle.
module tb_dpram_write_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_mem;
    logic       req_valid_a, req_we_a, req_valid_b, req_we_b;
    logic [3:0] req_addr_a, req_addr_b;
    logic [7:0] req_din_a, req_din_b;

    logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
    logic [7:0]  rsp_data_a, rsp_data_b, ram_din_a, ram_din_b;
    logic        ram_we_a, ram_we_b, conflict_pulse;
    logic [3:0]  ram_addr_a, ram_addr_b;
    logic [15:0] conflict_cnt;
    logic [7:0]  ram_dout_a, ram_dout_b;

    logic        req_ready_a_2, req_ready_b_2, rsp_valid_a_2, rsp_valid_b_2;
    logic [7:0]  rsp_data_a_2, rsp_data_b_2, ram_din_a_2, ram_din_b_2;
    logic        ram_we_a_2, ram_we_b_2, conflict_pulse_2;
    logic [3:0]  ram_addr_a_2, ram_addr_b_2;
    logic [1:0]  conflict_cnt_2;

    always #5 clk = ~clk;

    dpram_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_din_a(req_din_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_din_b(req_din_b),
        .rsp_valid_a(rsp_valid_a), .rsp_data_a(rsp_data_a),
        .rsp_valid_b(rsp_valid_b), .rsp_data_b(rsp_data_b),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b),
        .conflict_pulse(conflict_pulse), .conflict_cnt(conflict_cnt)
    );

    // Narrow-counter instance fed the same stimulus, for saturation checks
    dpram_write_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid_a(req_valid_a), .req_ready_a(req_ready_a_2), .req_we_a(req_we_a),
        .req_addr_a(req_addr_a), .req_din_a(req_din_a),
        .req_valid_b(req_valid_b), .req_ready_b(req_ready_b_2), .req_we_b(req_we_b),
        .req_addr_b(req_addr_b), .req_din_b(req_din_b),
        .rsp_valid_a(rsp_valid_a_2), .rsp_data_a(rsp_data_a_2),
        .rsp_valid_b(rsp_valid_b_2), .rsp_data_b(rsp_data_b_2),
        .ram_we_a(ram_we_a_2), .ram_addr_a(ram_addr_a_2), .ram_din_a(ram_din_a_2), .ram_dout_a(ram_dout_a),
        .ram_we_b(ram_we_b_2), .ram_addr_b(ram_addr_b_2), .ram_din_b(ram_din_b_2), .ram_dout_b(ram_dout_b),
        .conflict_pulse(conflict_pulse_2), .conflict_cnt(conflict_cnt_2)
    );

    // Read-first dual-port RAM with registered outputs
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else begin
            ram_dout_a <= mem[ram_addr_a];
            ram_dout_b <= mem[ram_addr_b];
            if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        end
    end

    typedef struct {
        int         due;
        logic [7:0] data;
    } rsp_t;

    rsp_t       qa[$];
    rsp_t       qb[$];
    logic [7:0] amem [16];
    logic       b_next;
    int         cnt_m;
    int         cyc;
    int         total;
    int         bad;
    logic       last_acc_a, last_acc_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst,
                        input logic va, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                        input logic vb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
        logic conf, era, erb, aca, acb, exp_pulse, exp_wea, exp_web, ev;
        int   sat16, sat2;
        rst_n = rst;
        req_valid_a = va; req_we_a = wa; req_addr_a = aa; req_din_a = da;
        req_valid_b = vb; req_we_b = wb; req_addr_b = ab; req_din_b = db;
        #1;
        if (!rst) begin
            qa.delete();
            qb.delete();
            b_next = 1'b0;
            cnt_m  = 0;
        end
        conf = va && vb && wa && wb && (aa == ab);
        era  = !(conf && b_next);
        erb  = !(conf && !b_next);
        chk("ready_a", 32'(req_ready_a), 32'(era));
        chk("ready_b", 32'(req_ready_b), 32'(erb));
        aca = rst && va && era;
        acb = rst && vb && erb;
        last_acc_a = aca;
        last_acc_b = acb;
        if (aca && wa) amem[aa] = da;
        if (acb && wb) amem[ab] = db;
        if (aca && !wa) qa.push_back('{cyc + 2, amem[aa]});
        if (acb && !wb) qb.push_back('{cyc + 2, amem[ab]});
        if (conf && rst) begin
            b_next = !b_next;
            cnt_m++;
        end
        exp_pulse = conf && rst;
        exp_wea   = aca && wa;
        exp_web   = acb && wb;

        @(posedge clk);
        cyc++;
        #1;
        sat16 = (cnt_m > 65535) ? 65535 : cnt_m;
        sat2  = (cnt_m > 3) ? 3 : cnt_m;
        chk("conflict_pulse", 32'(conflict_pulse), 32'(exp_pulse));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(sat16));
        chk("conflict_cnt_sat", 32'(conflict_cnt_2), 32'(sat2));
        chk("ram_we_a", 32'(ram_we_a), 32'(exp_wea));
        chk("ram_we_b", 32'(ram_we_b), 32'(exp_web));
        if (exp_wea) begin
            chk("ram_addr_a", 32'(ram_addr_a), 32'(aa));
            chk("ram_din_a", 32'(ram_din_a), 32'(da));
        end
        if (exp_web) begin
            chk("ram_addr_b", 32'(ram_addr_b), 32'(ab));
            chk("ram_din_b", 32'(ram_din_b), 32'(db));
        end
        chk("ram_pair_clash", 32'(ram_we_a && ram_we_b && (ram_addr_a == ram_addr_b)), 32'(0));
        if (!rst) begin
            chk("rst_ram_addr_a", 32'(ram_addr_a), 32'(0));
            chk("rst_ram_din_a", 32'(ram_din_a), 32'(0));
            chk("rst_ram_addr_b", 32'(ram_addr_b), 32'(0));
            chk("rst_ram_din_b", 32'(ram_din_b), 32'(0));
            chk("rst_rsp_data_a", 32'(rsp_data_a), 32'(0));
            chk("rst_rsp_data_b", 32'(rsp_data_b), 32'(0));
        end
        ev = (qa.size() > 0) && (qa[0].due == cyc);
        chk("rsp_valid_a", 32'(rsp_valid_a), 32'(ev));
        if (ev) begin
            chk("rsp_data_a", 32'(rsp_data_a), 32'(qa[0].data));
            void'(qa.pop_front());
        end
        ev = (qb.size() > 0) && (qb[0].due == cyc);
        chk("rsp_valid_b", 32'(rsp_valid_b), 32'(ev));
        if (ev) begin
            chk("rsp_data_b", 32'(rsp_data_b), 32'(qb[0].data));
            void'(qb.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pva, pwa, pvb, pwb;
        logic [3:0] paa, pab;
        logic [7:0] pda, pdb;

        total = 0; bad = 0; cyc = 0; cnt_m = 0; b_next = 1'b0;
        last_acc_a = 1'b0; last_acc_b = 1'b0;
        for (int i = 0; i < 16; i++) amem[i] = 8'h00;
        clr_mem = 1'b1;

        // Reset held with random request traffic
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                       1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        chk("rst_rsp_valid_a", 32'(rsp_valid_a), 32'(0));
        clr_mem = 1'b0;

        // First collision after release goes to A; B follows, then read back
        step(1'b1, 1'b1, 1'b1, 4'd3, 8'h11, 1'b1, 1'b1, 4'd3, 8'h22);
        step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd3, 8'h22);
        step(1'b1, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        idle(1);
        chk("readback_addr3", 32'(rsp_data_a), 32'h22);

        // Persistent collision for four cycles
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 4'd5, 8'hA0 + 8'(i), 1'b1, 1'b1, 4'd5, 8'hB0 + 8'(i));
        chk("cnt_after_persist", 32'(conflict_cnt), 32'd5);
        chk("cnt_saturated", 32'(conflict_cnt_2), 32'd3);

        // Forwarding: A reads addr 7 while B writes 0x5A there
        step(1'b1, 1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b1, 4'd7, 8'h5A);
        idle(1);
        chk("fwd_valid_a", 32'(rsp_valid_a), 32'd1);
        chk("fwd_data_a", 32'(rsp_data_a), 32'h5A);
        idle(1);

        // Streaming reads on A against writes on B
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b1, 4'(8 + i), 8'($urandom));
        idle(2);

        // Random traffic over a small address range, requests held until accepted
        pva = 1'b0; pvb = 1'b0;
        pwa = 1'b0; pwb = 1'b0; paa = 4'h0; pab = 4'h0; pda = 8'h00; pdb = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if (!pva && $urandom_range(0, 3) != 0) begin
                pva = 1'b1; pwa = ($urandom_range(0, 2) != 0);
                paa = 4'($urandom_range(0, 3)); pda = 8'($urandom);
            end
            if (!pvb && $urandom_range(0, 3) != 0) begin
                pvb = 1'b1; pwb = ($urandom_range(0, 2) != 0);
                pab = 4'($urandom_range(0, 3)); pdb = 8'($urandom);
            end
            step(1'b1, pva, pwa, paa, pda, pvb, pwb, pab, pdb);
            if (last_acc_a) pva = 1'b0;
            if (last_acc_b) pvb = 1'b0;
        end
        idle(3);

        // Mid-operation reset one cycle after a read accept
        step(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
        step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                   1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        idle(3);
        chk("cnt_after_reset", 32'(conflict_cnt), 32'd0);
        chk("cnt_sat_after_reset", 32'(conflict_cnt_2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
